// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the pipe_adder datapath: op-codes and the
// signed saturation limits used when PIPE_ADDER_SATURATE_EN is defined.
package pipe_adder_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ACC = 2'b10,
    OP_CLR = 2'b11
  } op_e;

  // Widest operand the saturation helper can describe.
  localparam int unsigned SAT_MAX_W = 64;

  // Signed two's-complement limit for a given width: min (1000..0) when
  // negative is set, max (0111..1) otherwise. Callers slice the low bits.
  function automatic logic [SAT_MAX_W-1:0] signed_limit(input int unsigned width,
                                                        input logic        negative);
    logic [SAT_MAX_W-1:0] msb_v;
    msb_v = 64'(1) << (width - 32'd1);
    if (negative) begin
      return msb_v;
    end else begin
      return msb_v - 64'd1;
    end
  endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle for pipe_adder. The master drives operands
// and consumer readiness; the slave (the adder) returns the result and flags.
interface pipe_adder_if #(
  parameter int WIDTH = 8
);
  import pipe_adder_pkg::*;

  logic             In_Valid;
  logic             In_Ready;
  logic [1:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Out_Valid;
  logic             Out_Ready;
  logic [WIDTH-1:0] Sum;
  logic             Carry;
  logic             Overflow;
  logic             Zero;

  modport master (
    output In_Valid, Op, A, B, Out_Ready,
    input  In_Ready, Out_Valid, Sum, Carry, Overflow, Zero
  );

  modport slave (
    input  In_Valid, Op, A, B, Out_Ready,
    output In_Ready, Out_Valid, Sum, Carry, Overflow, Zero
  );

endinterface

// File: rtl/pipe_adder_add_core.sv
// add_core: purely combinational WIDTH-bit adder/subtractor. Subtraction is
// done as a + ~b + 1, so cout is the raw carry-out (inverse of borrow).
module add_core #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH:0]   total_s;

  // Add a to b (or its complement plus one) and derive the signed overflow.
  always_comb begin
    b_eff_s = sub ? ~b : b;
    total_s = {1'b0, a} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, sub};
    sum     = total_s[WIDTH-1:0];
    cout    = total_s[WIDTH];
    // Overflow when both effective operands share a sign the result lacks.
    ovf     = (a[WIDTH-1] == b_eff_s[WIDTH-1]) && (total_s[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: registered add/subtract/accumulate unit with valid/ready on
// both sides and a one-entry output register (full throughput).
// Optional feature macro: PIPE_ADDER_SATURATE_EN clamps signed overflow to
// the signed max/min; left undefined, arithmetic wraps modulo 2^WIDTH.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  pipe_adder_if.slave  bus
);

`ifdef PIPE_ADDER_SATURATE_EN
  localparam logic [SAT_MAX_W-1:0] SAT_MAX_FULL = signed_limit(WIDTH, 1'b0);
  localparam logic [SAT_MAX_W-1:0] SAT_MIN_FULL = signed_limit(WIDTH, 1'b1);
  localparam logic [WIDTH-1:0]     SAT_MAX      = SAT_MAX_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0]     SAT_MIN      = SAT_MIN_FULL[WIDTH-1:0];
`endif

  op_e              op_s;
  logic             in_ready_s;
  logic             accept_s;
  logic             drain_s;

  logic [WIDTH-1:0] core_a_s;
  logic [WIDTH-1:0] core_b_s;
  logic             core_sub_s;
  logic [WIDTH-1:0] core_sum_s;
  logic             core_cout_s;
  logic             core_ovf_s;

  logic [WIDTH-1:0] result_sum_s;
  logic             result_carry_s;
  logic             result_ovf_s;
  logic             result_zero_s;

  logic             out_valid_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             ovf_r;
  logic             zero_r;
  logic [WIDTH-1:0] acc_r;

  assign op_s       = op_e'(bus.Op);
  assign in_ready_s = !out_valid_r || bus.Out_Ready;
  assign accept_s   = bus.In_Valid && in_ready_s;
  assign drain_s    = out_valid_r && bus.Out_Ready;

  // Steer operands: ACC adds A to the accumulator, SUB asks for a - b.
  always_comb begin
    core_a_s   = bus.A;
    core_b_s   = bus.B;
    core_sub_s = 1'b0;
    case (op_s)
      OP_SUB: begin
        core_sub_s = 1'b1;
      end
      OP_ACC: begin
        core_a_s = acc_r;
        core_b_s = bus.A;
      end
      default: begin
        core_sub_s = 1'b0;
      end
    endcase
  end

  add_core #(
    .WIDTH (WIDTH)
  ) u_add_core (
    .a    (core_a_s),
    .b    (core_b_s),
    .sub  (core_sub_s),
    .sum  (core_sum_s),
    .cout (core_cout_s),
    .ovf  (core_ovf_s)
  );

  // Form the result beat: carry/borrow per op, CLR forces a zero result,
  // optional clamping on signed overflow.
  always_comb begin
    result_sum_s   = core_sum_s;
    result_carry_s = core_cout_s;
    result_ovf_s   = core_ovf_s;
    case (op_s)
      OP_SUB: begin
        result_carry_s = !core_cout_s;
      end
      OP_CLR: begin
        result_sum_s   = {WIDTH{1'b0}};
        result_carry_s = 1'b0;
        result_ovf_s   = 1'b0;
      end
      default: begin
        result_carry_s = core_cout_s;
      end
    endcase
`ifdef PIPE_ADDER_SATURATE_EN
    // A non-negative first operand can only overflow upward, and vice versa.
    if ((op_s != OP_CLR) && core_ovf_s) begin
      result_sum_s = core_a_s[WIDTH-1] ? SAT_MIN : SAT_MAX;
    end else begin
      result_sum_s = result_sum_s;
    end
`endif
    result_zero_s = (result_sum_s == {WIDTH{1'b0}});
  end

  // Output register and accumulator: load on accept, release on drain.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      out_valid_r <= 1'b0;
      sum_r       <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      ovf_r       <= 1'b0;
      zero_r      <= 1'b1;
      acc_r       <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      sum_r       <= result_sum_s;
      carry_r     <= result_carry_s;
      ovf_r       <= result_ovf_s;
      zero_r      <= result_zero_s;
      case (op_s)
        OP_ACC:  acc_r <= result_sum_s;
        OP_CLR:  acc_r <= {WIDTH{1'b0}};
        default: acc_r <= acc_r;
      endcase
    end else if (drain_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign bus.In_Ready  = in_ready_s;
  assign bus.Out_Valid = out_valid_r;
  assign bus.Sum       = sum_r;
  assign bus.Carry     = carry_r;
  assign bus.Overflow  = ovf_r;
  assign bus.Zero      = zero_r;

endmodule
